// File: rtl/coin_arbiter.sv
// Two-port coin arbiter that multiplexes port A/B coin streams into one vending machine.
// Optional grant statistics are built when COIN_ARB_STATS_EN is defined.

module coin_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // NOTE: storage carries no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

module coin_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             a_dollar,
  input  logic             b_valid,
  input  logic             b_dollar,
  output logic             a_ready,
  output logic             b_ready,
  output logic             a_dispense,
  output logic             b_dispense,
  output logic             a_change,
  output logic             b_change,
  output logic             vm_rstn,
  output logic             vm_d_in,
  output logic             vm_q_in,
  input  logic             vm_dispense,
  input  logic             vm_change,
  output logic [1:0]       owner,
  output logic [CNT_W-1:0] a_grants,
  output logic [CNT_W-1:0] b_grants
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, HOLD} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  state_t     state, state_d;
  logic [1:0] owner_q, owner_d;
  logic       prio_b, prio_d;
  logic       a_disp_d, b_disp_d, a_chg_d, b_chg_d;

  logic a_full, a_empty, a_head, a_push, a_pop;
  logic b_full, b_empty, b_head, b_push, b_pop;
  logic own_a, own_b, own_empty, own_head;
  logic grant_a, grant_b;

  assign vm_rstn = ~rst;
  assign a_ready = ~rst & ~a_full;
  assign b_ready = ~rst & ~b_full;
  assign a_push  = a_valid & a_ready;
  assign b_push  = b_valid & b_ready;

  coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clock (clock),
    .rst   (rst),
    .push  (a_push),
    .din   (a_dollar),
    .pop   (a_pop),
    .dout  (a_head),
    .full  (a_full),
    .empty (a_empty)
  );

  coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clock (clock),
    .rst   (rst),
    .push  (b_push),
    .din   (b_dollar),
    .pop   (b_pop),
    .dout  (b_head),
    .full  (b_full),
    .empty (b_empty)
  );

  assign owner     = owner_q;
  assign own_a     = (owner_q == OWN_A);
  assign own_b     = (owner_q == OWN_B);
  assign own_empty = own_a ? a_empty : b_empty;
  assign own_head  = own_a ? a_head  : b_head;

  // Round-robin: prio_b marks that A was granted last, so B wins a tie next.
  assign grant_a = (state == IDLE) & ~a_empty & (b_empty | ~prio_b);
  assign grant_b = (state == IDLE) & ~b_empty & (a_empty |  prio_b);

  assign vm_d_in = (state == ISSUE) &  own_head;
  assign vm_q_in = (state == ISSUE) & ~own_head;
  assign a_pop   = (state == ISSUE) & own_a;
  assign b_pop   = (state == ISSUE) & own_b;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    owner_d  = owner_q;
    prio_d   = prio_b;
    a_disp_d = 1'b0;
    b_disp_d = 1'b0;
    a_chg_d  = 1'b0;
    b_chg_d  = 1'b0;
    unique case (state)
      IDLE: begin
        owner_d = OWN_NONE;
        if (grant_a) begin
          owner_d = OWN_A;
          prio_d  = 1'b1;
          state_d = ISSUE;
        end else if (grant_b) begin
          owner_d = OWN_B;
          prio_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (vm_dispense) begin
          a_disp_d = own_a;
          b_disp_d = own_b;
          a_chg_d  = own_a & vm_change;
          b_chg_d  = own_b & vm_change;
          owner_d  = OWN_NONE;
          state_d  = IDLE;
        end else if (!own_empty) begin
          // Back-to-back coins of one transaction issue every second cycle.
          state_d = ISSUE;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: if (!own_empty) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      owner_q    <= OWN_NONE;
      prio_b     <= 1'b0;
      a_dispense <= 1'b0;
      b_dispense <= 1'b0;
      a_change   <= 1'b0;
      b_change   <= 1'b0;
    end else begin
      state      <= state_d;
      owner_q    <= owner_d;
      prio_b     <= prio_d;
      a_dispense <= a_disp_d;
      b_dispense <= b_disp_d;
      a_change   <= a_chg_d;
      b_change   <= b_chg_d;
    end
  end

`ifdef COIN_ARB_STATS_EN
  logic [CNT_W-1:0] a_cnt, b_cnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (grant_a && (a_cnt != '1)) a_cnt <= a_cnt + 1'b1;
      if (grant_b && (b_cnt != '1)) b_cnt <= b_cnt + 1'b1;
    end
  end

  assign a_grants = a_cnt;
  assign b_grants = b_cnt;
`else
  assign a_grants = '0;
  assign b_grants = '0;
`endif

  a_coin_exclusive: assert property (@(posedge clock) disable iff (rst) !(vm_d_in && vm_q_in));
  a_no_pop_empty:   assert property (@(posedge clock) disable iff (rst) !((a_pop && a_empty) || (b_pop && b_empty)));

endmodule

// File: tb/tb_coin_arbiter.sv
// Randomised scoreboard bench for coin_arbiter with a behavioural vending machine
// (price 75 cents) and a transaction-level model of ownership, coin order and results.

module tb_coin_arbiter;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;
  localparam int PRICE      = 75;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             a_valid = 1'b0, a_dollar = 1'b0;
  logic             b_valid = 1'b0, b_dollar = 1'b0;
  logic             a_ready, b_ready;
  logic             a_dispense, b_dispense, a_change, b_change;
  logic             vm_rstn, vm_d_in, vm_q_in;
  logic             vm_dispense, vm_change;
  logic [1:0]       owner;
  logic [CNT_W-1:0] a_grants, b_grants;

  always #5 clock = ~clock;

  coin_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_dollar    (a_dollar),
    .b_valid     (b_valid),
    .b_dollar    (b_dollar),
    .a_ready     (a_ready),
    .b_ready     (b_ready),
    .a_dispense  (a_dispense),
    .b_dispense  (b_dispense),
    .a_change    (a_change),
    .b_change    (b_change),
    .vm_rstn     (vm_rstn),
    .vm_d_in     (vm_d_in),
    .vm_q_in     (vm_q_in),
    .vm_dispense (vm_dispense),
    .vm_change   (vm_change),
    .owner       (owner),
    .a_grants    (a_grants),
    .b_grants    (b_grants)
  );

  // Vending machine: accumulates credit, answers one cycle after a coin.
  int vm_credit;
  always @(posedge clock) begin
    if (!vm_rstn) begin
      vm_credit   <= 0;
      vm_dispense <= 1'b0;
      vm_change   <= 1'b0;
    end else if (vm_d_in || vm_q_in) begin
      automatic int c = vm_credit + (vm_d_in ? 100 : 25);
      if (c >= PRICE) begin
        vm_dispense <= 1'b1;
        vm_change   <= (c > PRICE);
        vm_credit   <= 0;
      end else begin
        vm_dispense <= 1'b0;
        vm_change   <= 1'b0;
        vm_credit   <= c;
      end
    end else begin
      vm_dispense <= 1'b0;
      vm_change   <= 1'b0;
    end
  end

  typedef struct packed {
    logic [1:0] port;
    logic       change;
  } res_t;

  bit         exp_a[$];
  bit         exp_b[$];
  res_t       exp_res[$];
  logic [1:0] done_log[$];
  logic [1:0] sb_owner = 2'b00;
  int         sb_credit = 0;
  int         mdl_ga = 0, mdl_gb = 0;
  int         n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every coin into the machine and every result pulse is checked here.
  int cyc = 0, last_issue = -10;
  always @(negedge clock) begin
    logic [1:0] p;
    bit         want;
    res_t       r;
    cyc++;
    if (!rst) begin
      if (vm_d_in || vm_q_in) begin
        check("coin_exclusive", {31'd0, vm_d_in & vm_q_in}, 0);
        check("issue_spacing", {31'd0, (cyc - last_issue) >= 2}, 1);
        last_issue = cyc;
        p = owner;
        check("issue_owner_valid", {31'd0, (p == 2'b01) || (p == 2'b10)}, 1);
        if (sb_owner == 2'b00) begin
          sb_owner = p;
          if (p == 2'b01 && mdl_ga < CNT_MAX) mdl_ga++;
          if (p == 2'b10 && mdl_gb < CNT_MAX) mdl_gb++;
        end else begin
          check("issue_owner_kept", {30'd0, p}, {30'd0, sb_owner});
        end
        if (p == 2'b01 && exp_a.size() > 0) begin
          want = exp_a.pop_front();
          check("a_coin_type", {31'd0, vm_d_in}, {31'd0, want});
        end else if (p == 2'b10 && exp_b.size() > 0) begin
          want = exp_b.pop_front();
          check("b_coin_type", {31'd0, vm_d_in}, {31'd0, want});
        end else begin
          check("coin_expected", 0, 1);
        end
        sb_credit += vm_d_in ? 100 : 25;
        if (sb_credit >= PRICE) begin
          r.port   = p;
          r.change = (sb_credit > PRICE);
          exp_res.push_back(r);
          sb_credit = 0;
          sb_owner  = 2'b00;
        end
      end
      if (a_dispense || b_dispense || a_change || b_change) begin
        check("result_one_port", {31'd0, a_dispense ^ b_dispense}, 1);
        check("change_needs_dispense",
              {31'd0, (a_change & ~a_dispense) | (b_change & ~b_dispense)}, 0);
        if (exp_res.size() == 0) begin
          check("result_expected", 0, 1);
        end else begin
          r = exp_res.pop_front();
          check("result_port", {30'd0, b_dispense, a_dispense}, {30'd0, r.port});
          check("result_change", {31'd0, a_change | b_change}, {31'd0, r.change});
          done_log.push_back(r.port);
        end
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic step(input bit av, input bit ad, input bit bv, input bit bd);
    a_valid  = av && a_ready;
    a_dollar = ad;
    b_valid  = bv && b_ready;
    b_dollar = bd;
    if (a_valid) exp_a.push_back(ad);
    if (b_valid) exp_b.push_back(bd);
    @(posedge clock); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic push_port(input bit port_b, input bit dollar);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (port_b ? b_ready : a_ready) begin
        step(!port_b, dollar, port_b, dollar);
        done = 1;
      end else begin
        idle(1);
      end
    end
    check("push_timeout", {31'd0, done}, 1);
  endtask

  // Finish any open transaction with dollars and wait for all results.
  task automatic drain();
    bit quiet = 0;
    for (int i = 0; i < 3000 && !quiet; i++) begin
      quiet = (exp_a.size() == 0) && (exp_b.size() == 0) && (exp_res.size() == 0) &&
              (sb_owner == 2'b00);
      if (!quiet) begin
        if (sb_owner == 2'b01 && exp_a.size() == 0 && a_ready) step(1, 1, 0, 0);
        else if (sb_owner == 2'b10 && exp_b.size() == 0 && b_ready) step(0, 0, 1, 1);
        else idle(1);
      end
    end
    check("drain_timeout", {31'd0, quiet}, 1);
    idle(3);
    check("owner_idle_after_drain", {30'd0, owner}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    exp_a.delete();
    exp_b.delete();
    exp_res.delete();
    done_log.delete();
    sb_owner  = 2'b00;
    sb_credit = 0;
    mdl_ga    = 0;
    mdl_gb    = 0;
    @(posedge clock); #1;
    @(negedge clock);
    check("rst_vm_rstn", {31'd0, vm_rstn}, 0);
    check("rst_ready", {30'd0, a_ready, b_ready}, 0);
    check("rst_owner", {30'd0, owner}, 0);
    check("rst_pulses", {28'd0, a_dispense, b_dispense, vm_d_in, vm_q_in}, 0);
    check("rst_grants", {a_grants, b_grants}, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    check("post_rst_ready", {30'd0, a_ready, b_ready}, 3);
    check("post_rst_owner", {30'd0, owner}, 0);
    @(posedge clock); #1;
  endtask

  task automatic check_grants(input string tag);
    int ea, eb;
`ifdef COIN_ARB_STATS_EN
    ea = mdl_ga;
    eb = mdl_gb;
`else
    ea = 0;
    eb = 0;
`endif
    check({tag, "_a_grants"}, {24'd0, a_grants}, ea);
    check({tag, "_b_grants"}, {24'd0, b_grants}, eb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_exp;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Three quarters on A complete one purchase without change.
    push_port(0, 0);
    push_port(0, 0);
    push_port(0, 0);
    drain();
    check("q3_results", done_log.size(), 1);
    if (done_log.size() > 0) check("q3_port", {30'd0, done_log[0]}, 1);
    done_log.delete();

    // B's dollar waits while A holds a partial credit.
    push_port(0, 0);
    idle(4);
    push_port(1, 1);
    idle(6);
    check("b_coin_buffered", exp_b.size(), 1);
    check("a_still_owner", {30'd0, owner}, 1);
    push_port(0, 1);
    drain();
    check("hold_results", done_log.size(), 2);
    if (done_log.size() == 2) begin
      check("hold_first_a", {30'd0, done_log[0]}, 1);
      check("hold_then_b", {30'd0, done_log[1]}, 2);
    end
    check_grants("hold");

    // Simultaneous dollars after reset: A first, then B.
    do_reset();
    step(1, 1, 1, 1);
    drain();
    check("tie_results", done_log.size(), 2);
    if (done_log.size() == 2) begin
      check("tie_first_a", {30'd0, done_log[0]}, 1);
      check("tie_then_b", {30'd0, done_log[1]}, 2);
    end
    check_grants("tie");
    done_log.delete();

    // A fills its FIFO while B holds the machine.
    push_port(1, 0);
    idle(4);
    push_port(0, 1);
    push_port(0, 1);
    check("a_full_not_ready", {31'd0, a_ready}, 0);
    repeat (5) step(1, 0, 0, 0);
    check("a_held_not_ready", {31'd0, a_ready}, 0);
    check("a_coins_waiting", exp_a.size(), 2);
    push_port(1, 0);
    push_port(1, 0);
    push_port(0, 0);
    drain();
    check("full_results", done_log.size(), 4);
    done_log.delete();

    // Reset during RESP abandons the transaction.
    do_reset();
    push_port(0, 1);
    for (int i = 0; i < 20 && !vm_d_in; i++) idle(1);
    check("issue_seen", {31'd0, vm_d_in}, 1);
    idle(1);
    do_reset();
    idle(6);
    check("abandon_no_result", done_log.size(), 0);
    check("abandon_owner", {30'd0, owner}, 0);
    check("abandon_no_issue", {30'd0, vm_d_in, vm_q_in}, 0);

    // Randomised traffic.
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    drain();
    check_grants("random");

    // Grant counter saturation.
    do_reset();
    for (int i = 0; i < CNT_MAX + 5; i++) push_port(0, 1);
    drain();
`ifdef COIN_ARB_STATS_EN
    sat_exp = CNT_MAX;
`else
    sat_exp = 0;
`endif
    check("a_grants_saturate", {24'd0, a_grants}, sat_exp);
    check_grants("sat");

    check("end_queues_empty", exp_a.size() + exp_b.size() + exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
